// File: rtl/contador_secuenciador.sv
`default_nettype none
// ============================================================================
// Module   : contador_secuenciador
// Function : Command-driven sequencer for the 16-bit mode counter. Accepts a
//            parallel load or an N-cycle run (up-1, down-1, up-3) over a
//            valid/ready handshake and reports the final count.
//            Optional build macro: SEQ_RCO_STOP_EN (stop a run early on RCO).
// Revision : 1.0 - initial release
// ============================================================================
module contador_secuenciador #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             enb,
    output logic [1:0]       modo,
    output logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] q,
    input  logic             rco,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             aborted
);

    localparam logic [1:0]       c_op_load = 2'b11;
    localparam logic [WIDTH-1:0] c_one     = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_rem;
    logic             r_enb;
    logic [1:0]       r_modo;
    logic [WIDTH-1:0] r_d;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_aborted;
    logic             w_rco_stop;

`ifdef SEQ_RCO_STOP_EN
    // RCO gates the enable combinationally so the counter never steps past
    // its terminal value; the same condition ends the run at the next edge.
    assign w_rco_stop = (r_state == S_RUN) && rco;
    assign enb        = r_enb && !w_rco_stop;
`else
    logic w_unused_rco;
    assign w_unused_rco = rco;
    assign w_rco_stop   = 1'b0;
    assign enb          = r_enb;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_rem     <= '0;
            r_enb     <= 1'b0;
            r_modo    <= c_op_load;
            r_d       <= '0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_aborted <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && r_ready) begin
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        if (cmd_op == c_op_load) begin
                            r_state <= S_LOAD;
                            r_enb   <= 1'b1;
                            r_modo  <= c_op_load;
                            r_d     <= cmd_data;
                        end else if (cmd_data == '0) begin
                            // Zero-length run: nothing to count, report at once.
                            r_state   <= S_DONE;
                            r_enb     <= 1'b0;
                            r_modo    <= c_op_load;
                            r_d       <= '0;
                            r_done    <= 1'b1;
                            r_aborted <= 1'b0;
                        end else begin
                            r_state <= S_RUN;
                            r_rem   <= cmd_data;
                            r_enb   <= 1'b1;
                            r_modo  <= cmd_op;
                            r_d     <= '0;
                        end
                    end
                end

                S_LOAD: begin
                    r_state   <= S_DONE;
                    r_enb     <= 1'b0;
                    r_modo    <= c_op_load;
                    r_d       <= '0;
                    r_done    <= 1'b1;
                    r_aborted <= 1'b0;
                end

                S_RUN: begin
                    if (w_rco_stop || (r_rem == c_one)) begin
                        r_state   <= S_DONE;
                        r_enb     <= 1'b0;
                        r_modo    <= c_op_load;
                        r_done    <= 1'b1;
                        r_aborted <= w_rco_stop;
                    end else begin
                        r_rem <= r_rem - c_one;
                    end
                end

                S_DONE: begin
                    r_state  <= S_IDLE;
                    r_result <= q;
                    r_done   <= 1'b0;
                    r_ready  <= 1'b1;
                    r_busy   <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_enb   <= 1'b0;
                    r_modo  <= c_op_load;
                    r_d     <= '0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Counter is frozen in DONE, so its live value is final while DONE is high;
    // the captured copy then holds it until the next command completes.
    assign result    = (r_state == S_DONE) ? q : r_result;
    assign modo      = r_modo;
    assign d         = r_d;
    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign aborted   = r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_contador_secuenciador.sv
`default_nettype none
// Testbench for contador_secuenciador: drives commands against a behavioural
// mode counter and checks results, enable timing and handshake behaviour.
module tb_contador_secuenciador;

    localparam int               WIDTH = 16;
    localparam logic [WIDTH-1:0] MAXV  = '1;
`ifdef SEQ_RCO_STOP_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [WIDTH-1:0] cmd_data = '0;
    logic             enb;
    logic [1:0]       modo;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] cnt_q = '0;
    logic             cnt_rco;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             aborted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    contador_secuenciador #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .enb       (enb),
        .modo      (modo),
        .d         (d),
        .q         (cnt_q),
        .rco       (cnt_rco),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .aborted   (aborted)
    );

    // Mode counter the sequencer drives
    always @(posedge clk) begin
        if (enb) begin
            case (modo)
                2'b00:   cnt_q <= cnt_q + 16'd1;
                2'b01:   cnt_q <= cnt_q - 16'd1;
                2'b10:   cnt_q <= cnt_q + 16'd3;
                default: cnt_q <= d;
            endcase
        end
    end

    always_comb begin
        cnt_rco = 1'b0;
        case (modo)
            2'b00:   cnt_rco = (cnt_q == MAXV);
            2'b01:   cnt_rco = (cnt_q == '0);
            2'b10:   cnt_rco = (cnt_q > MAXV - 16'd3);
            default: cnt_rco = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic at_terminal(input logic [1:0] op, input logic [WIDTH-1:0] v);
        case (op)
            2'b00:   return v == MAXV;
            2'b01:   return v == '0;
            2'b10:   return v >= MAXV - 16'd2;
            default: return 1'b0;
        endcase
    endfunction

    // Reference: final count, enabled-cycle count and abort flag of one command
    function automatic void predict(input logic [1:0] op, input logic [WIDTH-1:0] data,
                                    input logic [WIDTH-1:0] q0, output logic [WIDTH-1:0] q1,
                                    output int ec, output logic ab);
        int step;
        q1 = q0;
        ec = 0;
        ab = 1'b0;
        if (op == 2'b11) begin
            q1 = data;
            ec = 1;
            return;
        end
        step = (op == 2'b00) ? 1 : (op == 2'b01) ? -1 : 3;
        if (!STOP_EN) begin
            q1 = q0 + WIDTH'(step * int'(data));
            ec = int'(data);
        end else begin
            for (int i = 0; i < int'(data); i++) begin
                if (at_terminal(op, q1)) begin
                    ab = 1'b1;
                    break;
                end
                q1 = q1 + WIDTH'(step);
                ec++;
            end
        end
    endfunction

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [WIDTH-1:0] data,
                           input logic [WIDTH-1:0] exp_res, input int exp_enb, input logic exp_ab);
        int  guard, lat, enbc;
        bit  shape_ok, got_done;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        guard = 0;
        while (!cmd_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check({tag, " ready"}, cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_data  = WIDTH'($urandom);
        lat = 1; enbc = 0; shape_ok = 1'b1; got_done = 1'b0;
        while (lat < exp_enb + 20) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (!busy || cmd_ready) shape_ok = 1'b0;
            if (enb) begin
                enbc++;
                if (modo !== op) shape_ok = 1'b0;
                if (d !== ((op == 2'b11) ? data : '0)) shape_ok = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        check({tag, " done_seen"}, got_done, 1);
        check({tag, " latency"}, lat, exp_enb + 1 + int'(exp_ab));
        check({tag, " enb_cycles"}, enbc, exp_enb);
        check({tag, " shape"}, shape_ok, 1);
        check({tag, " result"}, result, exp_res);
        check({tag, " aborted"}, aborted, exp_ab);
        check({tag, " done_outs"}, {enb, modo, busy, cmd_ready}, {1'b0, 2'b11, 1'b1, 1'b0});
        @(negedge clk);
        check({tag, " idle_outs"}, {done, busy, cmd_ready}, {1'b0, 1'b0, 1'b1});
        check({tag, " result_hold"}, result, exp_res);
    endtask

    typedef struct {
        logic [1:0]       op;
        logic [WIDTH-1:0] data;
        logic [WIDTH-1:0] res;
        int               enbc;
        logic             ab;
    } vec_t;

    vec_t tab[10];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] qm, q1, seen_res, data;
        logic [1:0]       op;
        logic             ab;
        int               ec, waited;
        bit               flag;

        tab[0] = '{2'b11, 16'd120,   16'd120,   1,  1'b0};
        tab[1] = '{2'b11, 16'd0,     16'd0,     1,  1'b0};
        tab[2] = '{2'b00, 16'd10,    16'd10,    10, 1'b0};
        tab[3] = '{2'b11, 16'd120,   16'd120,   1,  1'b0};
        tab[4] = '{2'b01, 16'd5,     16'd115,   5,  1'b0};
        tab[5] = '{2'b11, 16'd0,     16'd0,     1,  1'b0};
        tab[6] = '{2'b10, 16'd4,     16'd12,    4,  1'b0};
        tab[7] = '{2'b00, 16'd0,     16'd12,    0,  1'b0};
        tab[8] = '{2'b11, 16'hFFFE,  16'hFFFE,  1,  1'b0};
`ifdef SEQ_RCO_STOP_EN
        tab[9] = '{2'b00, 16'd4,     16'hFFFF,  1,  1'b1};
`else
        tab[9] = '{2'b00, 16'd4,     16'd2,     4,  1'b0};
`endif

        #1 reset = 1'b1;
        #2;
        check("reset_enb", enb, 0);
        check("reset_modo", modo, 2'b11);
        check("reset_d", d, 0);
        check("reset_ready", cmd_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        check("reset_aborted", aborted, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++)
            run_cmd($sformatf("vec%0d", i), tab[i].op, tab[i].data, tab[i].res, tab[i].enbc, tab[i].ab);
        qm = tab[9].res;

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            if (op == 2'b11) begin
                case ($urandom_range(0, 2))
                    0:       data = WIDTH'($urandom);
                    1:       data = MAXV - WIDTH'($urandom_range(0, 5));
                    default: data = WIDTH'($urandom_range(0, 5));
                endcase
            end else begin
                data = WIDTH'($urandom_range(0, 40));
            end
            predict(op, data, qm, q1, ec, ab);
            run_cmd($sformatf("rnd%0d", i), op, data, q1, ec, ab);
            qm = q1;
        end

        // Reset in the middle of a long run
        run_cmd("pre_reset_load", 2'b11, 16'd0, 16'd0, 1, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 16'd100;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (19) @(negedge clk);
        check("run20_enb", enb, 1);
        #2 reset = 1'b1;
        #1;
        check("midreset_outs", {enb, cmd_ready, done, busy, aborted}, {1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        check("midreset_result", result, 0);
        @(negedge clk);
        reset = 1'b0;
        flag = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy || enb) flag = 1'b1;
        end
        check("after_reset_quiet", flag, 0);

        // Command held valid across a run is accepted exactly once when idle
        run_cmd("held_pre_load", 2'b11, 16'd7, 16'd7, 1, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 16'd5;
        @(negedge clk);
        cmd_op = 2'b11; cmd_data = 16'h0055;
        waited = 0; seen_res = '0;
        while (!cmd_ready && waited < 50) begin
            if (done) seen_res = result;
            @(negedge clk);
            waited++;
        end
        check("held_wait", waited, 6);
        check("held_run_result", seen_res, 16'd12);
        @(negedge clk);
        check("held_load_outs", {enb, modo, d}, {1'b1, 2'b11, 16'h0055});
        cmd_valid = 1'b0;
        @(negedge clk);
        check("held_load_done", {done, result}, {1'b1, 16'h0055});
        @(negedge clk);
        @(negedge clk);
        check("held_single_accept", {busy, enb, cmd_ready}, {1'b0, 1'b0, 1'b1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
